// File: rtl/fb_pkg.sv
// Framebuffer arbiter shared constants and types.
// Geometry, RAM widths and the read-pipeline tag.
package fb_pkg;

  localparam int H_ACTIVE = 200;
  localparam int V_REPEAT = 4;
  localparam int FB_WORDS = 30000;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 3;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_SCAN,
    TAG_HOST
  } rd_tag_e;

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Scanout address generator: line_base, rep_cnt, scan_addr, overrun.
// Ports: frame/line pulses, fetch_en in; scan_addr, scan_oob, scan_overrun out.
module fb_scan_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              scan_oob,
  output logic              scan_overrun
);

  localparam int REP_W = (V_REPEAT > 1) ? $clog2(V_REPEAT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(V_REPEAT - 1);

  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] line_base_d;
  logic [ADDR_W-1:0] base_clr;
  logic [ADDR_W-1:0] scan_addr_d;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_cnt_d;
  logic [REP_W-1:0]  rep_clr;
  logic              overrun_d;

  assign scan_oob = {{(32-ADDR_W){1'b0}}, scan_addr} >= 32'(FB_WORDS);

  // frame_start is applied first so a coincident line_start
  // sees the cleared base and repeat count.
  always_comb begin
    base_clr    = frame_start ? '0 : line_base;
    rep_clr     = frame_start ? '0 : rep_cnt;
    line_base_d = base_clr;
    rep_cnt_d   = rep_clr;
    scan_addr_d = scan_addr;
    overrun_d   = scan_overrun;
    if (line_start) begin
      scan_addr_d = base_clr;
      if (rep_clr == REP_LAST) begin
        rep_cnt_d   = '0;
        line_base_d = base_clr + ADDR_W'(H_ACTIVE);
      end else begin
        rep_cnt_d = rep_clr + REP_W'(1);
      end
    end else if (fetch_en) begin
      scan_addr_d = scan_addr + ADDR_W'(1);
    end
    if (frame_start)
      overrun_d = 1'b0;
    else if (fetch_en && scan_oob)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base    <= '0;
      rep_cnt      <= '0;
      scan_addr    <= '0;
      scan_overrun <= 1'b0;
    end else begin
      line_base    <= line_base_d;
      rep_cnt      <= rep_cnt_d;
      scan_addr    <= scan_addr_d;
      scan_overrun <= overrun_d;
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: scanout has fixed priority over host.
// Ports: timing pulses/fetch_en, pixel out, host cmd/rsp, RAM port, overrun.
module fb_scan_arbiter
  import fb_pkg::*;
(
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              fetch_en,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              scan_overrun
);

  logic [ADDR_W-1:0] scan_addr;
  logic              scan_oob;
  logic              host_go;
  rd_tag_e           tag_d;
  rd_tag_e           tag_q;
  logic              zero_q;

  fb_scan_addr_gen u_addr (
    .clk          (CLK),
    .rst_n        (RESETN),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .fetch_en     (fetch_en),
    .scan_addr    (scan_addr),
    .scan_oob     (scan_oob),
    .scan_overrun (scan_overrun)
  );

  assign cmd_ready = !fetch_en;
  assign host_go   = cmd_valid && !fetch_en;

  // Out-of-range scan fetches skip the RAM; their pixel is forced to 0.
  assign ram_en    = fetch_en ? !scan_oob : cmd_valid;
  assign ram_we    = host_go && cmd_we;
  assign ram_addr  = fetch_en ? scan_addr : cmd_addr;
  assign ram_wdata = cmd_wdata;

  always_comb begin
    tag_d = TAG_NONE;
    unique case (1'b1)
      fetch_en:            tag_d = TAG_SCAN;
      host_go && !cmd_we:  tag_d = TAG_HOST;
      default:             tag_d = TAG_NONE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tag_q  <= TAG_NONE;
      zero_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      zero_q <= fetch_en && scan_oob;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      pix_valid <= (tag_q == TAG_SCAN);
      rsp_valid <= (tag_q == TAG_HOST);
      if (tag_q == TAG_SCAN)
        pix_data <= zero_q ? '0 : ram_rdata;
      if (tag_q == TAG_HOST)
        rsp_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Randomized bench for fb_scan_arbiter with a frame-level reference model.
// Drives timing pulses and host traffic; models RAM and expected outputs.
module tb_fb_scan_arbiter;
  import fb_pkg::*;

  logic              CLK = 1'b0;
  logic              RESETN = 1'b0;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              fetch_en = 1'b0;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              scan_overrun;

  fb_scan_arbiter dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .fetch_en     (fetch_en),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .scan_overrun (scan_overrun)
  );

  always #50 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // synchronous RAM, 1-cycle read latency
  logic             preload = 1'b0;
  logic [DATA_W-1:0] mem [0:32767];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32768; i++) mem[i] <= DATA_W'(i);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // reference model: scan address = row*H_ACTIVE + pixel index,
  // row = line number within frame / V_REPEAT
  logic [DATA_W-1:0] model_mem [0:32767];
  int  lcnt = 0, row = 0, pix = 0;
  bit  ovr = 0;
  bit  e1_pv = 0, e2_pv = 0, e1_hv = 0, e2_hv = 0;
  int  e1_pd = 0, e2_pd = 0, e1_hd = 0, e2_hd = 0;

  always @(negedge CLK) begin
    int  addr;
    bit  oob, exp_en;
    if (preload)
      for (int i = 0; i < 32768; i++) model_mem[i] = DATA_W'(i);
    if (!RESETN) begin
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_overrun", scan_overrun, 0);
      lcnt = 0; row = 0; pix = 0; ovr = 0;
      e1_pv = 0; e2_pv = 0; e1_hv = 0; e2_hv = 0;
    end else begin
      addr = (row * H_ACTIVE + pix) % 32768;
      oob  = addr >= FB_WORDS;
      chk("cmd_ready", cmd_ready, !fetch_en);
      exp_en = fetch_en ? !oob : cmd_valid;
      chk("ram_en", ram_en, exp_en);
      if (exp_en) begin
        chk("ram_we", ram_we, !fetch_en && cmd_we);
        chk("ram_addr", ram_addr, fetch_en ? addr : int'(cmd_addr));
        if (!fetch_en && cmd_we) chk("ram_wdata", ram_wdata, cmd_wdata);
      end
      chk("pix_valid", pix_valid, e2_pv);
      if (e2_pv) chk("pix_data", pix_data, e2_pd);
      chk("rsp_valid", rsp_valid, e2_hv);
      if (e2_hv) chk("rsp_rdata", rsp_rdata, e2_hd);
      chk("scan_overrun", scan_overrun, ovr);
      e2_pv = e1_pv; e2_pd = e1_pd; e2_hv = e1_hv; e2_hd = e1_hd;
      e1_pv = fetch_en;
      e1_pd = oob ? 0 : int'(model_mem[addr]);
      e1_hv = !fetch_en && cmd_valid && !cmd_we;
      e1_hd = model_mem[cmd_addr];
      if (!fetch_en && cmd_valid && cmd_we) model_mem[cmd_addr] = cmd_wdata;
      if (frame_start) begin
        lcnt = 0; ovr = 0;
      end
      if (line_start) begin
        row = lcnt / V_REPEAT;
        pix = 0;
        lcnt++;
      end else if (fetch_en) begin
        pix++;
      end
      if (fetch_en && oob) ovr = 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_cmd(input bit en);
    cmd_valid = en && ($urandom % 2 == 1);
    cmd_we    = ($urandom % 2 == 1);
    if ($urandom % 4 == 0) cmd_addr = ADDR_W'($urandom_range(0, FB_WORDS - 1));
    else cmd_addr = ADDR_W'($urandom_range(0, 15));
    cmd_wdata = DATA_W'($urandom);
  endtask

  task automatic do_line(input bit fs, input bit host, input int nfetch);
    frame_start = fs;
    line_start  = 1'b1;
    rand_cmd(host);
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    rand_cmd(host);
    step();
    for (int i = 0; i < nfetch; i++) begin
      fetch_en = 1'b1;
      rand_cmd(host);
      step();
    end
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_cmd(host);
      step();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int waited;
    preload = 1'b1;
    step(); step(); step();
    preload = 1'b0;
    step();
    RESETN = 1'b1;
    step();

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step(); step();
    do_line(1'b0, 1'b0, H_ACTIVE);
    for (int l = 1; l < 10; l++) do_line(1'b0, 1'b1, H_ACTIVE);

    // held write during active fetch, then read it back
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_we = 1'b1;
    cmd_addr = ADDR_W'(5); cmd_wdata = DATA_W'(3);
    for (int i = 0; i < H_ACTIVE; i++) begin
      fetch_en = 1'b1;
      step();
    end
    fetch_en = 1'b0;
    waited = 0;
    @(negedge CLK);
    while (!(cmd_ready && cmd_valid) && waited < 10) begin
      waited++;
      @(negedge CLK);
    end
    chk("wr_accept_wait", waited, 0);
    step();
    cmd_we = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    @(negedge CLK);
    chk("rd5_valid", rsp_valid, 1);
    chk("rd5_data", rsp_rdata, 3);
    step();

    // frame_start coincident with line_start
    do_line(1'b1, 1'b1, H_ACTIVE);
    for (int l = 0; l < 4; l++) do_line(1'b0, 1'b1, H_ACTIVE);

    // run past the end of the framebuffer
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    for (int l = 0; l < 150 * V_REPEAT; l++) do_line(1'b0, 1'b0, 0);
    do_line(1'b0, 1'b1, H_ACTIVE);
    @(negedge CLK);
    chk("overrun_set", scan_overrun, 1);
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    @(negedge CLK);
    chk("overrun_clr", scan_overrun, 0);
    step();

    // reset with scanout and a host read in flight
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      fetch_en = 1'b1;
      step();
    end
    fetch_en = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = ADDR_W'(7);
    step();
    cmd_valid = 1'b0;
    RESETN = 1'b0;
    step(); step();
    RESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_pv", pix_valid, 0);
      chk("post_rst_rv", rsp_valid, 0);
      step();
    end
    do_line(1'b1, 1'b1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
